// File: rtl/video_mode_pkg.sv
// Shared types for the video mode controller: select encodings and control FSM states.
package video_mode_pkg;

    typedef enum logic [1:0] {
        BG_CAMERA  = 2'd0,
        BG_CHANNEL = 2'd1,
        BG_THRESH  = 2'd2,
        BG_YMASK   = 2'd3
    } bg_mode_t;

    typedef enum logic [1:0] {
        TGT_NONE  = 2'd0,
        TGT_CROSS = 2'd1,
        TGT_LINE  = 2'd2,
        TGT_BOTH  = 2'd3
    } tgt_mode_t;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } ctrl_state_t;

    function automatic bg_mode_t next_bg(input bg_mode_t v);
        return bg_mode_t'(v + 2'd1);
    endfunction

    function automatic tgt_mode_t next_tgt(input tgt_mode_t v);
        return tgt_mode_t'(v + 2'd1);
    endfunction

endpackage

// File: rtl/video_mode_ctrl_btn_debounce.sv
// Raw push-button synchronizer and debouncer producing an accepted level and a one-cycle press pulse.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level_out,
    output logic press_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q, level_dly_d;
    logic                   armed_q, armed_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], btn_in};
        prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
        cnt_d       = 16'd0;
        level_d     = level_q;
        level_dly_d = level_q;
        // A button held through reset must be seen released before its first press counts.
        armed_d     = armed_q | (prime_q[SYNC_STAGES-1] & ~synced & ~level_q);
        if (synced != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            prime_q     <= '0;
            cnt_q       <= 16'd0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prime_q     <= prime_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            armed_q     <= armed_d;
        end
    end

    assign level_out = level_q;
    assign press_out = level_q & ~level_dly_q & armed_q;

endmodule

// File: rtl/video_mode_ctrl.sv
// Background/overlay select controller: debounced buttons queue advances, auto-demo cycles modes,
// and all select changes are committed only on the frame-boundary pulse.
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  AUTO_FRAMES     = 8'd120,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic       clk_pixel_in,
    input  logic       rst_n_in,
    input  logic       btn_bg_in,
    input  logic       btn_target_in,
    input  logic       auto_en_in,
    input  logic       new_frame_in,
    output logic [1:0] bg_out,
    output logic [1:0] target_out,
    output logic       mode_changed_out,
    output logic       pending_out
);

    logic        bg_level, bg_press_raw, tgt_level, tgt_press_raw;
    logic        bg_press, tgt_press;
    ctrl_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    bg_mode_t    bg_q, bg_d;
    tgt_mode_t   tgt_q, tgt_d;
    logic        pend_bg_q, pend_bg_d, pend_tgt_q, pend_tgt_d;
    logic        mc_q, mc_d;
    logic        eff_bg, eff_tgt, auto_tick, bg_adv, tgt_adv;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_bg (
        .clk(clk_pixel_in), .rst_n(rst_n_in), .btn_in(btn_bg_in),
        .level_out(bg_level), .press_out(bg_press_raw)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db_tgt (
        .clk(clk_pixel_in), .rst_n(rst_n_in), .btn_in(btn_target_in),
        .level_out(tgt_level), .press_out(tgt_press_raw)
    );

    assign bg_press  = bg_press_raw & bg_level;
    assign tgt_press = tgt_press_raw & tgt_level;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bg_d       = bg_q;
        tgt_d      = tgt_q;
        pend_bg_d  = pend_bg_q | bg_press;
        pend_tgt_d = pend_tgt_q | tgt_press;
        mc_d       = 1'b0;

        // A press landing on the frame pulse is used directly, never parked in a flag.
        eff_bg    = pend_bg_q | bg_press;
        eff_tgt   = pend_tgt_q | tgt_press;
        auto_tick = (state_q == AUTO) && auto_en_in && new_frame_in
                    && (cnt_q == AUTO_FRAMES - 8'd1);
        bg_adv    = new_frame_in && (eff_bg || auto_tick);
        tgt_adv   = new_frame_in && (eff_tgt || (auto_tick && (bg_q == BG_YMASK)));

        case (state_q)
            MANUAL: begin
                if (auto_en_in) begin
                    state_d = AUTO;
                    cnt_d   = 8'd0;
                end
            end
            AUTO: begin
                if (!auto_en_in) begin
                    state_d = MANUAL;
                end else if (new_frame_in) begin
                    if (eff_bg || eff_tgt || (cnt_q == AUTO_FRAMES - 8'd1)) begin
                        cnt_d = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = MANUAL;
        endcase

        if (new_frame_in) begin
            pend_bg_d  = 1'b0;
            pend_tgt_d = 1'b0;
            mc_d       = bg_adv | tgt_adv;
            if (bg_adv) begin
                bg_d = next_bg(bg_q);
            end
            if (tgt_adv) begin
                tgt_d = next_tgt(tgt_q);
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= MANUAL;
            cnt_q      <= 8'd0;
            bg_q       <= BG_CAMERA;
            tgt_q      <= TGT_NONE;
            pend_bg_q  <= 1'b0;
            pend_tgt_q <= 1'b0;
            mc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bg_q       <= bg_d;
            tgt_q      <= tgt_d;
            pend_bg_q  <= pend_bg_d;
            pend_tgt_q <= pend_tgt_d;
            mc_q       <= mc_d;
        end
    end

    assign bg_out           = bg_q;
    assign target_out       = tgt_q;
    assign mode_changed_out = mc_q;
    assign pending_out      = pend_bg_q | pend_tgt_q;

endmodule
